// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg                                                              |
// | Shared constants, enums and byte-lane helpers for lsu_mmio_pipe.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package lsu_pkg;

  // Peripheral page numbers (addr[31:12]); each peripheral owns one 4 KB page.
  localparam logic [19:0] PAGE_LEDR   = 20'h10000;
  localparam logic [19:0] PAGE_LEDG   = 20'h10001;
  localparam logic [19:0] PAGE_HEX_LO = 20'h10002;
  localparam logic [19:0] PAGE_HEX_HI = 20'h10003;
  localparam logic [19:0] PAGE_LCD    = 20'h10004;
  localparam logic [19:0] PAGE_SW     = 20'h10010;

  // funct3 access types; the remaining encodings are illegal.
  typedef enum logic [2:0] {
    ACC_B  = 3'b000,
    ACC_H  = 3'b001,
    ACC_W  = 3'b010,
    ACC_BU = 3'b100,
    ACC_HU = 3'b101
  } access_e;

  // Response slot occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Decoded target of a request.
  typedef enum logic [2:0] {
    RGN_DMEM,
    RGN_LEDR,
    RGN_LEDG,
    RGN_HEX_LO,
    RGN_HEX_HI,
    RGN_LCD,
    RGN_SW,
    RGN_NONE
  } region_e;

  // Byte enables touched by an access of type f3 at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      ACC_B, ACC_BU: m = 4'b0001 << off;
      ACC_H, ACC_HU: m = off[1] ? 4'b1100 : 4'b0011;
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

  // Move right-aligned store data up into its byte lane.
  function automatic logic [31:0] store_align(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  // Replace only the enabled bytes of old_word with new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  // Shift the addressed lane down and sign/zero-extend per access type.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (f3)
      ACC_B:   r = {{24{sh[7]}}, sh[7:0]};
      ACC_BU:  r = {24'h0, sh[7:0]};
      ACC_H:   r = {{16{sh[15]}}, sh[15:0]};
      ACC_HU:  r = {16'h0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_dmem                                                             |
// | Word-organised synchronous data RAM with byte write enables and a    |
// | read-enable-gated output register. Contents are never reset.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_dmem #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and registered read; the output only moves on a read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mmio_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mmio_pipe                                                        |
// | Single-entry handshaked load/store unit: DMEM plus memory-mapped     |
// | LEDs, seven-segment, LCD and switches, with byte-lane alignment and  |
// | side-effect-free fault reporting.                                    |
// | Build option: LSU_SW_SYNC_EN adds a two-flop switch synchroniser.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lsu_mmio_pipe
  import lsu_pkg::*;
#(
  parameter int DMEM_BYTES = 2048,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_lsu_addr,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_type_access,
  input  logic [31:0] i_st_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_ld_data,
  output logic        o_rsp_err,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  input  logic [31:0] i_io_sw
);

  localparam int          DMEM_WORDS = DMEM_BYTES / 4;
  localparam int          DMEM_AW    = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [31:0] LEDR_MASK  = 32'((64'd1 << LEDR_W) - 64'd1);
  localparam logic [31:0] LEDG_MASK  = 32'((64'd1 << LEDG_W) - 64'd1);

  state_e      state_q, state_d;
  logic        accept;
  region_e     region;
  logic        req_err;
  logic [3:0]  be;
  logic [31:0] st_word;
  logic [31:0] periph_word;
  logic [31:0] sw_value;
  logic        wr_en;

  logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q, lcd_q;

  logic        rsp_err_q, rsp_load_q, rsp_dmem_q;
  logic [2:0]  rsp_f3_q;
  logic [1:0]  rsp_off_q;
  logic [31:0] periph_rdata_q;

  logic [31:0] dmem_rdata;
  logic [3:0]  dmem_we;
  logic        dmem_re;
  logic [31:0] ld_word;

`ifdef LSU_SW_SYNC_EN
  logic [31:0] sw_meta_q, sw_sync_q;

  // Two-flop synchroniser for the asynchronous switch pins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_io_sw;
      sw_sync_q <= sw_meta_q;
    end
  end
  assign sw_value = sw_sync_q;
`else
  assign sw_value = i_io_sw;
`endif

  // Address decode, fault detection, lane preparation and peripheral read mux.
  // DMEM claims every address below DMEM_BYTES; peripherals alias over their page.
  always_comb begin
    region = RGN_NONE;
    if (i_lsu_addr < 32'(DMEM_BYTES)) begin
      region = RGN_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        PAGE_LEDR:   region = RGN_LEDR;
        PAGE_LEDG:   region = RGN_LEDG;
        PAGE_HEX_LO: region = RGN_HEX_LO;
        PAGE_HEX_HI: region = RGN_HEX_HI;
        PAGE_LCD:    region = RGN_LCD;
        PAGE_SW:     region = RGN_SW;
        default:     region = RGN_NONE;
      endcase
    end

    req_err = 1'b0;
    case (i_type_access)
      ACC_B, ACC_BU: req_err = 1'b0;
      ACC_H, ACC_HU: req_err = i_lsu_addr[0];
      ACC_W:         req_err = (i_lsu_addr[1:0] != 2'b00);
      default:       req_err = 1'b1;
    endcase
    if (region == RGN_NONE) req_err = 1'b1;
    if (i_lsu_wren && (region == RGN_SW)) req_err = 1'b1;
    if (i_lsu_wren && ((i_type_access == ACC_BU) || (i_type_access == ACC_HU))) req_err = 1'b1;

    be      = lane_mask(i_type_access, i_lsu_addr[1:0]);
    st_word = store_align(i_st_data, i_lsu_addr[1:0]);

    case (region)
      RGN_LEDR:   periph_word = ledr_q;
      RGN_LEDG:   periph_word = ledg_q;
      RGN_HEX_LO: periph_word = hex_lo_q;
      RGN_HEX_HI: periph_word = hex_hi_q;
      RGN_LCD:    periph_word = lcd_q;
      RGN_SW:     periph_word = sw_value;
      default:    periph_word = '0;
    endcase
  end

  // Handshake and next-state logic for the single response slot.
  always_comb begin
    o_rsp_valid = (state_q == ST_FULL);
    o_req_ready = !o_rsp_valid || i_rsp_ready;
    accept      = i_req_valid && o_req_ready;
    state_d     = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if (o_rsp_valid && i_rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Slot occupancy register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  assign wr_en   = accept && i_lsu_wren && !req_err;
  assign dmem_we = (wr_en && (region == RGN_DMEM)) ? be : 4'b0000;
  assign dmem_re = accept && !i_lsu_wren && !req_err && (region == RGN_DMEM);

  // Response bookkeeping; frozen unless a new request is accepted.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rsp_err_q      <= 1'b0;
      rsp_load_q     <= 1'b0;
      rsp_dmem_q     <= 1'b0;
      rsp_f3_q       <= 3'b000;
      rsp_off_q      <= 2'b00;
      periph_rdata_q <= '0;
    end else if (accept) begin
      rsp_err_q      <= req_err;
      rsp_load_q     <= !i_lsu_wren && !req_err;
      rsp_dmem_q     <= (region == RGN_DMEM);
      rsp_f3_q       <= i_type_access;
      rsp_off_q      <= i_lsu_addr[1:0];
      periph_rdata_q <= periph_word;
    end
  end

  // Peripheral registers, written at the store's accepting edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_lo_q <= '0;
      hex_hi_q <= '0;
      lcd_q    <= '0;
    end else if (wr_en) begin
      case (region)
        RGN_LEDR:   ledr_q   <= byte_merge(ledr_q, st_word, be) & LEDR_MASK;
        RGN_LEDG:   ledg_q   <= byte_merge(ledg_q, st_word, be) & LEDG_MASK;
        RGN_HEX_LO: hex_lo_q <= byte_merge(hex_lo_q, st_word, be);
        RGN_HEX_HI: hex_hi_q <= byte_merge(hex_hi_q, st_word, be);
        RGN_LCD:    lcd_q    <= byte_merge(lcd_q, st_word, be);
        default:    ;
      endcase
    end
  end

  lsu_dmem #(
    .DEPTH (DMEM_WORDS),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clk   (i_clk),
    .addr  (i_lsu_addr[DMEM_AW+1:2]),
    .we    (dmem_we),
    .re    (dmem_re),
    .wdata (st_word),
    .rdata (dmem_rdata)
  );

  // Load result; forced to zero for stores, faults and straight after reset.
  always_comb begin
    ld_word   = rsp_dmem_q ? dmem_rdata : periph_rdata_q;
    o_ld_data = rsp_load_q ? load_extend(ld_word, rsp_f3_q, rsp_off_q) : 32'h0;
  end

  assign o_rsp_err = rsp_err_q;
  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex0 = hex_lo_q[6:0];
  assign o_io_hex1 = hex_lo_q[14:8];
  assign o_io_hex2 = hex_lo_q[22:16];
  assign o_io_hex3 = hex_lo_q[30:24];
  assign o_io_hex4 = hex_hi_q[6:0];
  assign o_io_hex5 = hex_hi_q[14:8];
  assign o_io_hex6 = hex_hi_q[22:16];
  assign o_io_hex7 = hex_hi_q[30:24];

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_mmio_pipe                                                     |
// | Scoreboard bench for lsu_mmio_pipe.                                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_lsu_mmio_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] lsu_addr = '0;
  logic        wren = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] st_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] ld_data;
  logic        rsp_err;
  logic [31:0] ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [31:0] sw = '0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] data;
    logic        err;
    logic [31:0] exp;
    int          pidx;
    logic [31:0] pexp;
  } vec_t;

  exp_t sb[$];

  lsu_mmio_pipe dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_lsu_addr    (lsu_addr),
    .i_lsu_wren    (wren),
    .i_type_access (f3),
    .i_st_data     (st_data),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_ld_data     (ld_data),
    .o_rsp_err     (rsp_err),
    .o_io_ledr     (ledr),
    .o_io_ledg     (ledg),
    .o_io_lcd      (lcd),
    .o_io_hex0     (hex0),
    .o_io_hex1     (hex1),
    .o_io_hex2     (hex2),
    .o_io_hex3     (hex3),
    .o_io_hex4     (hex4),
    .o_io_hex5     (hex5),
    .o_io_hex6     (hex6),
    .o_io_hex7     (hex7),
    .i_io_sw       (sw)
  );

  always #5 clk = ~clk;

  // Peripheral view selected by a table entry; hex digits packed one per byte.
  function automatic logic [31:0] periph_obs(input int p);
    case (p)
      1:       return ledr;
      2:       return ledg;
      3:       return lcd;
      4:       return {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};
      5:       return {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4};
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request, wait (bounded) for acceptance, record its expected response.
  task automatic send(input logic [31:0] a, input logic wr, input logic [2:0] t,
                      input logic [31:0] d, input logic e_err, input logic [31:0] e_data);
    int n;
    n = 0;
    req_valid = 1'b1;
    lsu_addr  = a;
    wren      = wr;
    f3        = t;
    st_data   = d;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{e_err, e_data});
  endtask

  task automatic test_reset();
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || ld_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rsp: valid=%b err=%b data=%h, want 0 0 00000000", rsp_valid, rsp_err, ld_data);
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 1", req_ready);
    end
    vectors++;
    if (ledr !== 32'h0 || ledg !== 32'h0 || lcd !== 32'h0 || periph_obs(4) !== 32'h0 || periph_obs(5) !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_periph: ledr=%h ledg=%h lcd=%h hexlo=%h hexhi=%h, want all 0",
               ledr, ledg, lcd, periph_obs(4), periph_obs(5));
    end
  endtask

  task automatic test_dmem_align();
    vec_t v[$];
    exp_t e;
    v.push_back('{32'h0000_0000, 1'b1, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0003, 1'b0, 3'b000, 32'h0,        1'b0, 32'hFFFFFFDE, 0, 32'h0});
    v.push_back('{32'h0000_0001, 1'b0, 3'b100, 32'h0,        1'b0, 32'h000000BE, 0, 32'h0});
    v.push_back('{32'h0000_0002, 1'b0, 3'b101, 32'h0,        1'b0, 32'h0000DEAD, 0, 32'h0});
    v.push_back('{32'h0000_0002, 1'b0, 3'b001, 32'h0,        1'b0, 32'hFFFFDEAD, 0, 32'h0});
    v.push_back('{32'h0000_0000, 1'b0, 3'b000, 32'h0,        1'b0, 32'hFFFFFFEF, 0, 32'h0});
    v.push_back('{32'h0000_0000, 1'b0, 3'b010, 32'h0,        1'b0, 32'hDEADBEEF, 0, 32'h0});
    v.push_back('{32'h0000_07FC, 1'b1, 3'b010, 32'h11223344, 1'b0, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_07FC, 1'b0, 3'b010, 32'h0,        1'b0, 32'h11223344, 0, 32'h0});
    v.push_back('{32'h0000_0004, 1'b1, 3'b010, 32'h0,        1'b0, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0005, 1'b1, 3'b000, 32'h123456A5, 1'b0, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0006, 1'b1, 3'b001, 32'h9999BEEF, 1'b0, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0004, 1'b0, 3'b010, 32'h0,        1'b0, 32'hBEEFA500, 0, 32'h0});
    foreach (v[i]) begin
      send(v[i].addr, v[i].wr, v[i].f3, v[i].data, v[i].err, v[i].exp);
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== e.err || ld_data !== e.data) begin
        miscompares++;
        $display("FAIL dmem_align[%0d]: valid=%b err=%b data=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, ld_data, e.err, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_periph();
    vec_t v[$];
    exp_t e;
    sw = 32'h12345678;
    v.push_back('{32'h1000_0001, 1'b1, 3'b000, 32'h0000005A, 1'b0, 32'h0,        1, 32'h00005A00});
    v.push_back('{32'h1000_0000, 1'b0, 3'b010, 32'h0,        1'b0, 32'h00005A00, 0, 32'h0});
    v.push_back('{32'h1000_0FFC, 1'b1, 3'b010, 32'hFFFFFFFF, 1'b0, 32'h0,        1, 32'h0001FFFF});
    v.push_back('{32'h1000_0002, 1'b1, 3'b000, 32'hFFFFFF00, 1'b0, 32'h0,        1, 32'h0000FFFF});
    v.push_back('{32'h1000_0000, 1'b0, 3'b010, 32'h0,        1'b0, 32'h0000FFFF, 0, 32'h0});
    v.push_back('{32'h1000_1000, 1'b1, 3'b010, 32'hFFFFFFFF, 1'b0, 32'h0,        2, 32'h000000FF});
    v.push_back('{32'h1000_1000, 1'b0, 3'b000, 32'h0,        1'b0, 32'hFFFFFFFF, 0, 32'h0});
    v.push_back('{32'h1000_4000, 1'b1, 3'b010, 32'hCAFEF00D, 1'b0, 32'h0,        3, 32'hCAFEF00D});
    v.push_back('{32'h1000_2000, 1'b1, 3'b010, 32'h0F0E0D0C, 1'b0, 32'h0,        4, 32'h0F0E0D0C});
    v.push_back('{32'h1000_3000, 1'b1, 3'b010, 32'h7F001234, 1'b0, 32'h0,        5, 32'h7F001234});
    v.push_back('{32'h1000_2000, 1'b1, 3'b000, 32'h000000FF, 1'b0, 32'h0,        4, 32'h0F0E0D7F});
    v.push_back('{32'h1000_2000, 1'b0, 3'b100, 32'h0,        1'b0, 32'h000000FF, 0, 32'h0});
    v.push_back('{32'h1001_0004, 1'b0, 3'b010, 32'h0,        1'b0, 32'h12345678, 0, 32'h0});
    v.push_back('{32'h1001_0003, 1'b0, 3'b100, 32'h0,        1'b0, 32'h00000012, 0, 32'h0});
    foreach (v[i]) begin
      send(v[i].addr, v[i].wr, v[i].f3, v[i].data, v[i].err, v[i].exp);
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== e.err || ld_data !== e.data) begin
        miscompares++;
        $display("FAIL periph[%0d]: valid=%b err=%b data=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, ld_data, e.err, e.data);
      end
      if (v[i].pidx != 0) begin
        vectors++;
        if (periph_obs(v[i].pidx) !== v[i].pexp) begin
          miscompares++;
          $display("FAIL periph_reg[%0d]: got %h, want %h", i, periph_obs(v[i].pidx), v[i].pexp);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    vec_t v[$];
    exp_t e;
    v.push_back('{32'h0000_0002, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0001, 1'b1, 3'b001, 32'h00000000, 1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h1001_0000, 1'b1, 3'b010, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h2000_0000, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0800, 1'b0, 3'b010, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0001, 1'b0, 3'b101, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0000, 1'b0, 3'b011, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h1000_0000, 1'b1, 3'b100, 32'h0,        1'b1, 32'h0, 1, 32'h0000FFFF});
    v.push_back('{32'h1000_4000, 1'b1, 3'b110, 32'h0,        1'b1, 32'h0, 3, 32'hCAFEF00D});
    v.push_back('{32'h1000_5000, 1'b1, 3'b010, 32'h0,        1'b1, 32'h0, 0, 32'h0});
    v.push_back('{32'h0000_0000, 1'b0, 3'b010, 32'h0,        1'b0, 32'hDEADBEEF, 0, 32'h0});
    foreach (v[i]) begin
      send(v[i].addr, v[i].wr, v[i].f3, v[i].data, v[i].err, v[i].exp);
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== e.err || ld_data !== e.data) begin
        miscompares++;
        $display("FAIL errors[%0d]: valid=%b err=%b data=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, ld_data, e.err, e.data);
      end
      if (v[i].pidx != 0) begin
        vectors++;
        if (periph_obs(v[i].pidx) !== v[i].pexp) begin
          miscompares++;
          $display("FAIL errors_reg[%0d]: got %h, want %h", i, periph_obs(v[i].pidx), v[i].pexp);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    exp_t e;
    v.push_back('{32'h0000_0040, 1'b1, 3'b010, 32'h13579BDF, 1'b0, 32'h0,        0, 32'h0});
    v.push_back('{32'h0000_0040, 1'b0, 3'b010, 32'h0,        1'b0, 32'h13579BDF, 0, 32'h0});
    v.push_back('{32'h0000_0041, 1'b1, 3'b000, 32'h00000000, 1'b0, 32'h0,        0, 32'h0});
    v.push_back('{32'h0000_0040, 1'b0, 3'b010, 32'h0,        1'b0, 32'h135700DF, 0, 32'h0});
    v.push_back('{32'h0000_0042, 1'b0, 3'b001, 32'h0,        1'b0, 32'h00001357, 0, 32'h0});
    foreach (v[i]) begin
      send(v[i].addr, v[i].wr, v[i].f3, v[i].data, v[i].err, v[i].exp);
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_err !== e.err || ld_data !== e.data) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: valid=%b err=%b data=%h, want 1 %b %h",
                 i, rsp_valid, rsp_err, ld_data, e.err, e.data);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    exp_t e;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    lsu_addr  = 32'h0;
    wren      = 1'b0;
    f3        = 3'b010;
    st_data   = 32'h0;
    @(posedge clk); #1;
    sb.push_back('{1'b0, 32'hDEADBEEF});
    lsu_addr = 32'h7FC;
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (rsp_valid !== 1'b1 || ld_data !== e.data || rsp_err !== e.err || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h err=%b ready=%b, want 1 %h %b 0",
                 c, rsp_valid, ld_data, rsp_err, req_ready, e.data, e.err);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b, want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back('{1'b0, 32'h11223344});
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || ld_data !== e.data || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL stall_next: valid=%b data=%h err=%b, want 1 %h %b", rsp_valid, ld_data, rsp_err, e.data, e.err);
    end
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain: valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    rsp_ready = 1'b0;
    send(32'h1000_0000, 1'b0, 3'b010, 32'h0, 1'b0, 32'h0000FFFF);
    e = sb.pop_front();
    @(posedge clk); #1;
    vectors++;
    if (rsp_valid !== 1'b1 || ld_data !== e.data || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL mid_stall_hold: valid=%b data=%h err=%b, want 1 %h %b", rsp_valid, ld_data, rsp_err, e.data, e.err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || ld_data !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_stall_reset: valid=%b data=%h err=%b ready=%b, want 0 00000000 0 1",
               rsp_valid, ld_data, rsp_err, req_ready);
    end
    vectors++;
    if (ledr !== 32'h0 || ledg !== 32'h0 || lcd !== 32'h0 || periph_obs(4) !== 32'h0 || periph_obs(5) !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_stall_periph: ledr=%h ledg=%h lcd=%h hexlo=%h hexhi=%h, want all 0",
               ledr, ledg, lcd, periph_obs(4), periph_obs(5));
    end
    #3;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    send(32'h0000_0000, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF);
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || ld_data !== e.data || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL dmem_after_reset: valid=%b data=%h err=%b, want 1 %h %b", rsp_valid, ld_data, rsp_err, e.data, e.err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_dmem_align();
    test_periph();
    test_errors();
    test_back_to_back();
    test_stall();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
